// File: rtl/pic_step_scheduler_pkg.sv
// Shared constants and types for the particle-in-cell timestep scheduler.
package pic_step_scheduler_pkg;

    // Default problem size for one timestep
    localparam int unsigned NUM_PARTICLES = 16384;
    localparam int unsigned NUM_CELLS     = 4096;
    localparam int unsigned NUM_IT        = 8;

    // Externally visible phase encoding
    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_CLEAR   = 3'd1;
    localparam logic [2:0] PH_SCATTER = 3'd2;
    localparam logic [2:0] PH_SOLVE   = 3'd3;
    localparam logic [2:0] PH_PUSH    = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCATTER,
        ST_SDRAIN,
        ST_SOLVE,
        ST_SWAIT,
        ST_PUSH,
        ST_PDRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pic_step_scheduler_idx_streamer.sv
// idx_streamer: valid/ready particle-index counter with terminal-count detect.
// Shared by the SCATTER and PUSH phases; the index wraps to 0 after the last handshake.
module idx_streamer #(
    parameter int unsigned COUNT = pic_step_scheduler_pkg::NUM_PARTICLES,
    parameter int unsigned IDX_W = $clog2(COUNT)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_ready,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last,
    output logic             o_done
);
    import pic_step_scheduler_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

    logic [IDX_W-1:0] r_idx;
    logic             w_fire;
    logic             w_last;

    assign w_last = (r_idx == LAST_IDX);
    assign w_fire = i_en && i_ready;

    assign o_idx  = r_idx;
    assign o_last = w_last;
    assign o_done = w_fire && w_last;

    // Index register: advances only on an accepted handshake, holds otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_idx <= '0;
        end else if (w_fire) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pic_step_scheduler.sv
// pic_step_scheduler: timestep sequencer for the PIC core.
// Phase order per step: CLEAR grid, SCATTER indices, NUM_IT solver iterations, PUSH indices.
// Optional feature macro STEP_LIMIT_EN: adds i_num_steps / o_step_cnt and runs
// back-to-back steps, pulsing o_done only after the final one.
module pic_step_scheduler #(
    parameter int unsigned NUM_PARTICLES = pic_step_scheduler_pkg::NUM_PARTICLES,
    parameter int unsigned NUM_CELLS     = pic_step_scheduler_pkg::NUM_CELLS,
    parameter int unsigned NUM_IT        = pic_step_scheduler_pkg::NUM_IT,
    parameter int unsigned PIDX_W        = $clog2(NUM_PARTICLES),
    parameter int unsigned GADDR_W       = $clog2(NUM_CELLS),
    parameter int unsigned IT_W          = $clog2(NUM_IT + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic [2:0]         o_phase,
    output logic               o_clr_we,
    output logic [GADDR_W-1:0] o_clr_addr,
    output logic               o_idx_valid,
    input  logic               i_idx_ready,
    output logic [PIDX_W-1:0]  o_idx,
    output logic               o_idx_last,
    input  logic               i_scatter_busy,
    input  logic               i_push_busy,
    output logic               o_solve_start,
    input  logic               i_solve_done,
`ifdef STEP_LIMIT_EN
    input  logic [15:0]        i_num_steps,
    output logic [15:0]        o_step_cnt,
`endif
    output logic [IT_W-1:0]    o_it_cnt
);
    import pic_step_scheduler_pkg::*;

    localparam logic [GADDR_W-1:0] CLR_LAST = GADDR_W'(NUM_CELLS - 1);
    localparam logic [IT_W-1:0]    IT_LAST  = IT_W'(NUM_IT);

    state_t             r_state;
    state_t             w_next;
    logic [GADDR_W-1:0] r_clr_addr;
    logic [IT_W-1:0]    r_it_cnt;
    logic [IT_W-1:0]    w_it_inc;
    logic               r_guard;
    logic               w_idx_en;
    logic               w_idx_load;
    logic               w_idx_done;
    logic               w_final_step;

    assign w_it_inc   = r_it_cnt + 1'b1;
    assign w_idx_en   = (r_state == ST_SCATTER) || (r_state == ST_PUSH);
    assign w_idx_load = (r_state == ST_IDLE) && i_start;
    assign o_clr_addr = r_clr_addr;
    assign o_it_cnt   = r_it_cnt;

    idx_streamer #(
        .COUNT (NUM_PARTICLES),
        .IDX_W (PIDX_W)
    ) u_idx_streamer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_idx_load),
        .i_en    (w_idx_en),
        .i_ready (i_idx_ready),
        .o_idx   (o_idx),
        .o_last  (o_idx_last),
        .o_done  (w_idx_done)
    );

`ifdef STEP_LIMIT_EN
    logic [15:0] r_num_steps;
    logic [15:0] r_step_cnt;

    assign w_final_step = (r_step_cnt == r_num_steps);
    assign o_step_cnt   = r_step_cnt;

    // Step bookkeeping: latch the requested count (0 means 1) and count completed steps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_num_steps <= 16'd1;
            r_step_cnt  <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_num_steps <= (i_num_steps == 16'd0) ? 16'd1 : i_num_steps;
            r_step_cnt  <= '0;
        end else if ((r_state == ST_PDRAIN) && (w_next == ST_DONE)) begin
            r_step_cnt  <= r_step_cnt + 16'd1;
        end
    end
`else
    assign w_final_step = 1'b1;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Phase counters: clear address, solver iterations, drain guard
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_addr <= '0;
            r_it_cnt   <= '0;
            r_guard    <= 1'b0;
        end else begin
            // Guard is set after the first drain cycle, so the exit test happens no
            // earlier than the second cycle, once downstream busy has had time to rise.
            r_guard <= ((r_state == ST_SDRAIN) || (r_state == ST_PDRAIN)) && (w_next == r_state);

            if ((r_state == ST_IDLE) && i_start) begin
                r_clr_addr <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_clr_addr <= (r_clr_addr == CLR_LAST) ? '0 : r_clr_addr + 1'b1;
            end

            if (((r_state == ST_IDLE) && i_start) || ((r_state == ST_DONE) && (w_next == ST_CLEAR))) begin
                r_it_cnt <= '0;
            end else if ((r_state == ST_SWAIT) && i_solve_done) begin
                r_it_cnt <= w_it_inc;
            end
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next        = r_state;
        o_busy        = 1'b1;
        o_done        = 1'b0;
        o_phase       = PH_IDLE;
        o_clr_we      = 1'b0;
        o_idx_valid   = 1'b0;
        o_solve_start = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                o_phase  = PH_CLEAR;
                o_clr_we = 1'b1;
                if (r_clr_addr == CLR_LAST) w_next = ST_SCATTER;
            end
            ST_SCATTER: begin
                o_phase     = PH_SCATTER;
                o_idx_valid = 1'b1;
                if (w_idx_done) w_next = ST_SDRAIN;
            end
            ST_SDRAIN: begin
                o_phase = PH_SCATTER;
                if (r_guard && !i_scatter_busy) w_next = ST_SOLVE;
            end
            ST_SOLVE: begin
                o_phase       = PH_SOLVE;
                o_solve_start = 1'b1;
                w_next        = ST_SWAIT;
            end
            ST_SWAIT: begin
                o_phase = PH_SOLVE;
                if (i_solve_done) w_next = (w_it_inc == IT_LAST) ? ST_PUSH : ST_SOLVE;
            end
            ST_PUSH: begin
                o_phase     = PH_PUSH;
                o_idx_valid = 1'b1;
                if (w_idx_done) w_next = ST_PDRAIN;
            end
            ST_PDRAIN: begin
                o_phase = PH_PUSH;
                if (r_guard && !i_push_busy) w_next = ST_DONE;
            end
            ST_DONE: begin
                // DONE is reported as the tail of the push phase
                o_phase = PH_PUSH;
                o_done  = w_final_step;
                w_next  = w_final_step ? ST_IDLE : ST_CLEAR;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
